dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and sequencer for the 8-bit data memory. It shares the single-ported data memory between the CPU load/store path (port A) and the debug/DMA loader (port B). Requests are granted round-robin and each access runs a fixed three-state sequence that matches the memory's one-clock registered read. The block sits between the requesters and the data memory; the top level owns the memory's bidirectional data bus and builds its tristate from `mem_wdata` and `mem_oe`.

## Interface
- `ADDR_W`, default 8: memory address width.
- `DATA_W`, default 8: memory data width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `a_req`  in  1  port A request; held high until `a_ready`.
- `a_we`  in  1  port A direction: 1 = write, 0 = read.
- `a_addr`  in  ADDR_W  port A address.
- `a_wdata`  in  DATA_W  port A write data.
- `a_ready`  out  1  one-cycle pulse: port A access complete.
- `a_rdata`  out  DATA_W  port A read data; valid with `a_ready` on reads, held until the next port A read completes.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ready`, `b_rdata`: same as port A, for port B.
- `mem_cmd`  out  1  memory command: 1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  data to drive onto the memory bus.
- `mem_oe`  out  1  bus drive enable for `mem_wdata`.
- `mem_rdata`  in  DATA_W  memory bus as seen by the arbiter.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, CAPTURE.
- **IDLE**
  - `mem_cmd`=0, `mem_oe`=0, `mem_addr`=0.
  - If either request is high, pick a winner, latch its `we`, `addr` and `wdata` into internal registers, record the winner, and go to ISSUE.
  - Otherwise stay in IDLE.
- **Arbitration**
  - Only one request high: that port wins.
  - Both high: the port not granted last wins.
  - `last_grant` resets to B, so A wins the first tie.
  - `last_grant` updates on the IDLE→ISSUE transition.
- **ISSUE** (exactly one cycle, always followed by CAPTURE)
  - `mem_addr` = latched address, `mem_cmd` = latched `we`.
  - `mem_oe` = latched `we`; `mem_wdata` = latched write data.
  - The memory samples the command and address on the edge that ends ISSUE.
- **CAPTURE** (exactly one cycle, always followed by IDLE)
  - `mem_cmd`=0, `mem_oe`=0.
  - The winner's `ready` is high for this cycle only.
  - On a read, the winner's `rdata` register loads `mem_rdata` on the edge that ends CAPTURE.
  - On a write, `rdata` is unchanged.
- Outputs other than `rdata` and `busy` are decoded from state and latched fields. `rdata` is registered.
- The loser's `req` stays pending and is re-arbitrated in the next IDLE. A requester that holds `req` high after `ready` issues a new access.
- Requester fields are sampled only in IDLE; changes after the grant are ignored.

## Timing
- Request first seen high at edge k (in IDLE) → ISSUE in cycle k+1 → CAPTURE with `ready` high in cycle k+2 → IDLE in k+3.
- Access latency is 3 cycles from request to completion. Peak throughput is one access per 3 cycles.
- `a_rdata`/`b_rdata` are valid from cycle k+3 onward.
- Back-to-back accesses with both ports requesting continuously are granted A, B, A, B, …
- **Reset** (asynchronous, any state):
  - State → IDLE, `last_grant` → B.
  - `a_ready`, `b_ready`, `mem_cmd`, `mem_oe`, `busy` → 0.
  - `mem_addr`, `mem_wdata`, `a_rdata`, `b_rdata` → 0.
- Reset during ISSUE forces `mem_cmd`=0 immediately. A write is not performed if reset is asserted before the closing edge. No `ready` is issued for the aborted access.
- Address is a full 8-bit field; no wrap or range check. Addresses 0 and 255 are legal.

## Test plan
- **Reset:** assert `rst` mid-cycle → all outputs 0 immediately, no edge required. Release → `busy`=0.
- **Single read:** preload mem[3]=0x03; A read addr 3 at edge k → `mem_cmd`=0, `mem_addr`=3 in k+1; `a_ready`=1 in k+2; `a_rdata`=0x03 from k+3; `b_ready` never high.
- **Write then read-back:** B writes 0xA5 to addr 0xFF → `mem_cmd`=1, `mem_oe`=1, `mem_wdata`=0xA5 in ISSUE; B then reads 0xFF → `b_rdata`=0xA5.
- **Contention:** A and B both request continuously with reads of addrs 1 and 2 → grant order A, B, A, B; `a_rdata`=0x01 and `b_rdata`=0x02; no cycle with both `ready` high.
- **Reset mid-write:** A writes 0x77 to addr 4; assert `rst` during ISSUE before the edge → mem[4] keeps 0x04, `a_ready` never pulses; after release, first A/B tie is granted to A.
- **Late field change:** A is granted a read of addr 1, then `a_addr` changes to 2 in ISSUE → `mem_addr` stays 1; `a_rdata`=0x01.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and IDLE/ISSUE/CAPTURE sequencer for the
// single-ported data memory shared by the CPU (A) and debug/DMA loader (B).
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ready,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ready,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    state_t state;
    state_t state_nx;

    logic              last_b;
    logic              win_b;
    logic              pick_b;
    logic              any_req;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    // B wins when alone, or on a tie when A was served last
    assign any_req = a_req | b_req;
    assign pick_b  = b_req & (~a_req | ~last_b);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = ISSUE;
            ISSUE:   state_nx = CAPTURE;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            win_b     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                win_b     <= pick_b;
                last_b    <= pick_b;
                lat_we    <= pick_b ? b_we : a_we;
                lat_addr  <= pick_b ? b_addr : a_addr;
                lat_wdata <= pick_b ? b_wdata : a_wdata;
            end
            if (state == CAPTURE && !lat_we) begin
                if (win_b) b_rdata <= mem_rdata;
                else       a_rdata <= mem_rdata;
            end
        end
    end

    assign mem_cmd   = (state == ISSUE) & lat_we;
    assign mem_oe    = (state == ISSUE) & lat_we;
    assign mem_addr  = (state == IDLE) ? '0 : lat_addr;
    assign mem_wdata = lat_wdata;
    assign a_ready   = (state == CAPTURE) & ~win_b;
    assign b_ready   = (state == CAPTURE) & win_b;
    assign busy      = (state != IDLE);

endmodule
